// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan capture monitor:
// glyph table, digit count, capture FSM states and the glyph decoder.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Active-high {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

    // Returns {valid, nibble}; unknown patterns (blank included) give 5'b0
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg7);
        logic [4:0] r;
        r = '0;
        case (seg7)
            GLYPH_0: r = 5'h10;
            GLYPH_1: r = 5'h11;
            GLYPH_2: r = 5'h12;
            GLYPH_3: r = 5'h13;
            GLYPH_4: r = 5'h14;
            GLYPH_5: r = 5'h15;
            GLYPH_6: r = 5'h16;
            GLYPH_7: r = 5'h17;
            GLYPH_8: r = 5'h18;
            GLYPH_9: r = 5'h19;
            GLYPH_A: r = 5'h1A;
            GLYPH_B: r = 5'h1B;
            GLYPH_C: r = 5'h1C;
            GLYPH_D: r = 5'h1D;
            GLYPH_E: r = 5'h1E;
            GLYPH_F: r = 5'h1F;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational active-high segment pattern to hex nibble decoder.
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        {valid, nibble} = decode_glyph(seg);
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Receive side of the multiplexed 8-digit seven-segment interface: waits for
// each digit to settle, decodes it, and publishes complete frames.
module seven_seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned FRAME_TIMEOUT = 2000000
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [31:0] digits,
    output logic [7:0]  dp_mask,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        stale
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);

    logic [7:0]  an_meta, an_sync, an_prev;
    logic [6:0]  seg_meta, seg_sync, seg_prev;
    logic        dp_meta, dp_sync, dp_prev;

    state_t      state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [7:0]  seen;
    logic [31:0] stg_digits;
    logic [7:0]  stg_dp;
    logic [7:0]  stg_valid;

    logic        cur_legal;
    logic        cur_changed;
    logic [2:0]  cur_idx;
    logic        capture;
    logic        timeout_hit;
    logic        dec_valid;
    logic [3:0]  dec_nibble;

    // Idle synchronizer value is an inactive bus (no anode, blank segments)
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            an_meta  <= '1;
            an_sync  <= '1;
            an_prev  <= '1;
            seg_meta <= '1;
            seg_sync <= '1;
            seg_prev <= '1;
            dp_meta  <= 1'b1;
            dp_sync  <= 1'b1;
            dp_prev  <= 1'b1;
        end else begin
            an_meta  <= an;
            an_sync  <= an_meta;
            an_prev  <= an_sync;
            seg_meta <= seg;
            seg_sync <= seg_meta;
            seg_prev <= seg_sync;
            dp_meta  <= dp;
            dp_sync  <= dp_meta;
            dp_prev  <= dp_sync;
        end
    end

    seven_seg_glyph_decode u_decode (
        .seg    (~seg_sync),
        .valid  (dec_valid),
        .nibble (dec_nibble)
    );

    always_comb begin
        cur_legal   = ($countones(~an_sync) == 1);
        cur_changed = ({an_sync, seg_sync, dp_sync} != {an_prev, seg_prev, dp_prev});
        cur_idx     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync[i]) cur_idx = 3'(i);
        end
        capture     = (state == SETTLE) && cur_legal && !cur_changed &&
                      (settle_cnt == SW'(SETTLE_CYCLES - 1));
        timeout_hit = !capture && (timeout_cnt == TW'(FRAME_TIMEOUT - 1));
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cur_legal) begin
                        state      <= SETTLE;
                        settle_cnt <= SW'(1);
                    end
                end
                SETTLE: begin
                    if (!cur_legal) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                    end else if (cur_changed) begin
                        settle_cnt <= SW'(1);
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                        if (capture) state <= CAPTURED;
                    end
                end
                CAPTURED: begin
                    if (cur_changed) begin
                        state      <= cur_legal ? SETTLE : IDLE;
                        settle_cnt <= cur_legal ? SW'(1) : '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

    // Commit fires the edge after seen fills; a capture cannot land on that edge
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            seen        <= '0;
            stg_digits  <= '0;
            stg_dp      <= '0;
            stg_valid   <= '0;
            timeout_cnt <= '0;
            digits      <= '0;
            dp_mask     <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            stale       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (capture) begin
                stg_digits[{cur_idx, 2'b00} +: 4] <= dec_nibble;
                stg_valid[cur_idx]                <= dec_valid;
                stg_dp[cur_idx]                   <= ~dp_sync;
                timeout_cnt                       <= '0;
            end else if (timeout_cnt != TW'(FRAME_TIMEOUT)) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end

            if (seen == '1) begin
                digits      <= stg_digits;
                dp_mask     <= stg_dp;
                digit_valid <= stg_valid;
                frame_done  <= 1'b1;
                stale       <= 1'b0;
                seen        <= '0;
            end else if (timeout_hit) begin
                seen  <= '0;
                stale <= 1'b1;
            end else if (capture) begin
                seen <= seen | ~an_sync;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture: scans digit patterns onto the
// active-low bus and checks the published frames against hand-computed values.
module tb_seven_seg_scan_capture;
    import seven_seg_pkg::*;

    logic        clk_100;
    logic        reset;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    seven_seg_scan_capture #(
        .SETTLE_CYCLES (16),
        .FRAME_TIMEOUT (500)
    ) dut (
        .clk_100     (clk_100),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .stale       (stale)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    always @(negedge clk_100) if (frame_done) fd_cnt++;

    // Active-low bus value for a hex digit
    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
        endcase
        return ~g;
    endfunction

    task automatic show(input int idx, input logic [6:0] s, input logic d, input int cycles);
        logic [7:0] one;
        one = 8'h01;
        an  = ~(one << idx);
        seg = s;
        dp  = d;
        repeat (cycles) @(negedge clk_100);
    endtask

    task automatic bus_idle(input int cycles);
        an  = 8'hFF;
        seg = 7'h7F;
        dp  = 1'b1;
        repeat (cycles) @(negedge clk_100);
    endtask

    task automatic scan(input logic [31:0] vals, input logic [7:0] dps,
                        input int first, input int last, input int short_idx);
        for (int i = first; i <= last; i++)
            show(i, enc(vals[4*i +: 4]), ~dps[i], (i == short_idx) ? 10 : 20);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        an = 8'hFF; seg = 7'h7F; dp = 1'b1;
        #2000;
        @(negedge clk_100);
        reset = 1'b0;
        repeat (20) @(negedge clk_100);
        checks++; if (digits !== 32'h0)      begin errors++; $display("FAIL reset_digits got=%h exp=%h", digits, 32'h0); end
        checks++; if (dp_mask !== 8'h00)     begin errors++; $display("FAIL reset_dp got=%h exp=00", dp_mask); end
        checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got=%h exp=00", digit_valid); end
        checks++; if (stale !== 1'b0)        begin errors++; $display("FAIL reset_stale got=%b exp=0", stale); end
        checks++; if (fd_cnt !== 0)          begin errors++; $display("FAIL reset_frame_done got=%0d exp=0", fd_cnt); end
        checks++; if (dut.state !== IDLE)    begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    endtask

    task automatic test_basic_frame;
        int base;
        base = fd_cnt;
        scan(32'h87654321, 8'h00, 0, 7, -1);
        bus_idle(10);
        checks++; if (fd_cnt - base !== 1)   begin errors++; $display("FAIL basic_pulses got=%0d exp=1", fd_cnt - base); end
        checks++; if (digits !== 32'h87654321) begin errors++; $display("FAIL basic_digits got=%h exp=87654321", digits); end
        checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL basic_valid got=%h exp=FF", digit_valid); end
        checks++; if (dp_mask !== 8'h00)     begin errors++; $display("FAIL basic_dp got=%h exp=00", dp_mask); end
    endtask

    task automatic test_glitch_digit;
        int base;
        base = fd_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) show(i, 7'b0110110, 1'b0, 20);
            else        show(i, enc(4'hF), 1'b1, 20);
        end
        bus_idle(10);
        checks++; if (fd_cnt - base !== 1)   begin errors++; $display("FAIL glitch_pulses got=%0d exp=1", fd_cnt - base); end
        checks++; if (digits !== 32'hFFFF0FFF) begin errors++; $display("FAIL glitch_digits got=%h exp=FFFF0FFF", digits); end
        checks++; if (digit_valid !== 8'hF7) begin errors++; $display("FAIL glitch_valid got=%h exp=F7", digit_valid); end
        checks++; if (dp_mask !== 8'h08)     begin errors++; $display("FAIL glitch_dp got=%h exp=08", dp_mask); end
    endtask

    task automatic test_short_digit_timeout;
        int base;
        base = fd_cnt;
        scan(32'h76543210, 8'h00, 0, 7, 2);
        scan(32'h76543210, 8'h00, 0, 7, 2);
        bus_idle(450);
        checks++; if (fd_cnt - base !== 0)   begin errors++; $display("FAIL short_pulses got=%0d exp=0", fd_cnt - base); end
        checks++; if (stale !== 1'b0)        begin errors++; $display("FAIL early_stale got=%b exp=0", stale); end
        repeat (70) @(negedge clk_100);
        checks++; if (stale !== 1'b1)        begin errors++; $display("FAIL timeout_stale got=%b exp=1", stale); end
        checks++; if (digits !== 32'hFFFF0FFF) begin errors++; $display("FAIL timeout_digits got=%h exp=FFFF0FFF", digits); end
        checks++; if (digit_valid !== 8'hF7) begin errors++; $display("FAIL timeout_valid got=%h exp=F7", digit_valid); end
        checks++; if (fd_cnt - base !== 0)   begin errors++; $display("FAIL timeout_pulses got=%0d exp=0", fd_cnt - base); end
    endtask

    task automatic test_multi_anode;
        int base;
        base = fd_cnt;
        scan(32'h23456789, 8'h20, 0, 3, -1);
        an = 8'hF0; seg = enc(4'h8); dp = 1'b0;
        repeat (50) @(negedge clk_100);
        checks++; if (fd_cnt - base !== 0)   begin errors++; $display("FAIL multi_pulses got=%0d exp=0", fd_cnt - base); end
        scan(32'h23456789, 8'h20, 4, 7, -1);
        bus_idle(10);
        checks++; if (fd_cnt - base !== 1)   begin errors++; $display("FAIL multi_frame got=%0d exp=1", fd_cnt - base); end
        checks++; if (digits !== 32'h23456789) begin errors++; $display("FAIL multi_digits got=%h exp=23456789", digits); end
        checks++; if (dp_mask !== 8'h20)     begin errors++; $display("FAIL multi_dp got=%h exp=20", dp_mask); end
        checks++; if (stale !== 1'b0)        begin errors++; $display("FAIL stale_clear got=%b exp=0", stale); end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        scan(32'h55555555, 8'h00, 0, 4, -1);
        #2 reset = 1'b1;
        #1;
        checks++; if (digits !== 32'h0)      begin errors++; $display("FAIL midreset_digits got=%h exp=0", digits); end
        checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL midreset_valid got=%h exp=00", digit_valid); end
        checks++; if (dp_mask !== 8'h00)     begin errors++; $display("FAIL midreset_dp got=%h exp=00", dp_mask); end
        bus_idle(5);
        reset = 1'b0;
        base = fd_cnt;
        scan(32'h10FEDCBA, 8'h00, 5, 7, -1);
        bus_idle(10);
        checks++; if (fd_cnt - base !== 0)   begin errors++; $display("FAIL partial_pulses got=%0d exp=0", fd_cnt - base); end
        scan(32'h10FEDCBA, 8'h00, 0, 7, -1);
        bus_idle(10);
        checks++; if (fd_cnt - base !== 1)   begin errors++; $display("FAIL postreset_pulses got=%0d exp=1", fd_cnt - base); end
        checks++; if (digits !== 32'h10FEDCBA) begin errors++; $display("FAIL postreset_digits got=%h exp=10FEDCBA", digits); end
        checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL postreset_valid got=%h exp=FF", digit_valid); end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_glitch_digit;
        test_short_digit_timeout;
        test_multi_anode;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
